// File: rtl/hazard_sched_pkg.sv
// ============================================================================
// hazard_sched_pkg : shared constants for the hazard scheduler
// Revision 1.0
// ============================================================================
`default_nettype none

package hazard_sched_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int SLOT_V_W   = 1;
  localparam int SLOT_DST_W = 5;
  localparam int SLOT_LD_W  = 1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_sched_if.sv
// ============================================================================
// hazard_sched_if : ID-stage request and hazard control bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface hazard_sched_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_reg_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_branch_taken;
  logic             stall;
  logic             bubble;
  logic             flush_ifid;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_reg_dst, id_reg_write, id_mem_read, ex_branch_taken,
    input  stall, bubble, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_reg_dst, id_reg_write, id_mem_read, ex_branch_taken,
    output stall, bubble, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_sched_match.sv
// ============================================================================
// hazard_match : one source register against one in-flight destination slot
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_match
  import hazard_sched_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  wire logic [REG_W-1:0] src,
  input  wire logic             uses,
  input  wire logic             slot_v,
  input  wire logic [REG_W-1:0] slot_dst,
  output logic                  hit
);

  // $0 is hard-wired, so reading it never depends on an older writer
  assign hit = slot_v & uses & (src != REG_W'(REG_ZERO)) & (src == slot_dst);

endmodule

`default_nettype wire

// File: rtl/hazard_sched.sv
// ============================================================================
// hazard_sched : stall/bubble/flush generation and forwarding selects
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int FORWARD_EN = 1,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input wire logic      clk,
  input wire logic      rst_n,
  hazard_sched_if.slave hs
);

  logic [SLOT_V_W-1:0]  ex_v;
  logic [REG_W-1:0]     ex_dst;
  logic [SLOT_LD_W-1:0] ex_ld;
  logic [SLOT_V_W-1:0]  mem_v;
  logic [REG_W-1:0]     mem_dst;

  logic [REG_W-1:0] id_dst;
  logic             id_entry_v;
  logic             rs_ex, rt_ex, rs_mem, rt_mem;
  logic             raw_stall;
  logic             stall, bubble, flush;
  logic [1:0]       fwd_a_nxt, fwd_b_nxt;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign id_dst     = hs.id_reg_dst ? hs.id_rd : hs.id_rt;
  assign id_entry_v = hs.id_valid & hs.id_reg_write & (id_dst != REG_W'(REG_ZERO));

  hazard_match #(.REG_W(REG_W)) u_rs_ex (
    .src(hs.id_rs), .uses(hs.id_uses_rs), .slot_v(ex_v[0]), .slot_dst(ex_dst), .hit(rs_ex)
  );
  hazard_match #(.REG_W(REG_W)) u_rt_ex (
    .src(hs.id_rt), .uses(hs.id_uses_rt), .slot_v(ex_v[0]), .slot_dst(ex_dst), .hit(rt_ex)
  );
  hazard_match #(.REG_W(REG_W)) u_rs_mem (
    .src(hs.id_rs), .uses(hs.id_uses_rs), .slot_v(mem_v[0]), .slot_dst(mem_dst), .hit(rs_mem)
  );
  hazard_match #(.REG_W(REG_W)) u_rt_mem (
    .src(hs.id_rt), .uses(hs.id_uses_rt), .slot_v(mem_v[0]), .slot_dst(mem_dst), .hit(rt_mem)
  );

  generate
    if (FORWARD_EN != 0) begin : g_fwd
      // Only a load in EX cannot be bypassed in time
      assign raw_stall = hs.id_valid & (rs_ex | rt_ex) & ex_ld[0];
    end else begin : g_nofwd
      assign raw_stall = hs.id_valid & (rs_ex | rt_ex | rs_mem | rt_mem);
    end
  endgenerate

  // A taken branch kills the ID instruction, so its hazards are moot
  assign flush  = hs.ex_branch_taken;
  assign stall  = raw_stall & ~flush;
  assign bubble = flush | stall;

  always_comb begin
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
    if ((FORWARD_EN != 0) && !bubble) begin
      if (rs_ex)       fwd_a_nxt = FWD_EXMEM;
      else if (rs_mem) fwd_a_nxt = FWD_MEMWB;
      if (rt_ex)       fwd_b_nxt = FWD_EXMEM;
      else if (rt_mem) fwd_b_nxt = FWD_MEMWB;
    end
  end

  // The MEM slot drops the load flag: its data is already available to bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v    <= '0;
      ex_dst  <= '0;
      ex_ld   <= '0;
      mem_v   <= '0;
      mem_dst <= '0;
      fwd_a   <= FWD_RF;
      fwd_b   <= FWD_RF;
    end else begin
      mem_v   <= ex_v;
      mem_dst <= ex_dst;
      ex_v    <= bubble ? 1'b0 : id_entry_v;
      ex_dst  <= id_dst;
      ex_ld   <= hs.id_mem_read;
      fwd_a   <= fwd_a_nxt;
      fwd_b   <= fwd_b_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hs.stall      = stall;
  assign hs.bubble     = bubble;
  assign hs.flush_ifid = flush;
  assign hs.fwd_a      = fwd_a;
  assign hs.fwd_b      = fwd_b;
  assign hs.stall_cnt  = stall_cnt;
  assign hs.flush_cnt  = flush_cnt;

endmodule

`default_nettype wire

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
Pipeline hazard scheduler for the 5-stage MIPS core.
- Tracks the destination register of in-flight instructions in the EX and MEM stages. The destination is selected by RegDst: rt or rd.
- Compares the ID-stage instruction's sources against those destinations and generates stall, bubble and flush controls.
- Produces registered forwarding selects for the EX-stage ALU operand muxes.
- Keeps saturating stall and flush performance counters.

Parameters:
FORWARD_EN, 1, 1 = EX/MEM and MEM/WB forwarding enabled (only load-use stalls); 0 = no forwarding (stall until the producer reaches WB).
REG_W, 5, register-address width.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_W  source register rs
id_rt  input  REG_W  source register rt / I-type destination
id_rd  input  REG_W  R-type destination
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
id_reg_dst  input  1  0 = destination is rt, 1 = destination is rd
id_reg_write  input  1  instruction writes the register file
id_mem_read  input  1  instruction is a load
ex_branch_taken  input  1  branch in EX resolved taken this cycle
stall  output  1  hold PC and IF/ID (combinational)
bubble  output  1  zero ID/EX control fields (combinational)
flush_ifid  output  1  clear IF/ID (combinational)
fwd_a  output  2  ALU operand A select, valid while the instruction is in EX (registered)
fwd_b  output  2  ALU operand B select (registered)
stall_cnt  output  CNT_W  saturating count of stall cycles
flush_cnt  output  CNT_W  saturating count of flush cycles

Behaviour:
- Asynchronous reset (rst_n low) clears:
  - EX and MEM slots invalid.
  - fwd_a and fwd_b = 00.
  - stall_cnt and flush_cnt = 0.
  - Combinational outputs are then 0, except as driven by the current inputs.
- Reset asserted mid-operation discards all slots immediately. There is no stall or forwarding after release until new writers enter.
- ID destination: id_dst = id_reg_dst ? id_rd : id_rt.
- ID entry is valid only when id_valid & id_reg_write & (id_dst != 0). Writes to $0 never create a hazard.
- Slot contents: {v, dst, ld}. Every clock:
  - MEM <= EX.
  - EX <= ID entry, except EX <= invalid when bubble = 1.
- A source matches a slot when: the slot's v = 1, the source is used, the source is nonzero, and the source equals the slot's dst.
- WB-stage writers are never hazards: the register file writes before it reads.
- Stall condition, FORWARD_EN = 1: id_valid and (rs or rt matches the EX slot with ld = 1). This is exactly one stall cycle.
- Stall condition, FORWARD_EN = 0: id_valid and (rs or rt matches the EX or MEM slot). This is up to 2 consecutive stall cycles.
- Flush: ex_branch_taken = 1 gives flush_ifid = 1 and bubble = 1, and forces stall = 0. Flush has priority over stall because the ID instruction is on the wrong path.
- Otherwise, bubble = stall.
- Forwarding encoding: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
  - Computed from ID sources and registered on the edge where the instruction advances into EX.
  - A match against the EX slot gives 10. A match against the MEM slot gives 01. The EX slot has priority when both match.
  - When bubble = 1, or FORWARD_EN = 0, the registered value is 00.
- Counters:
  - stall_cnt increments on each clock where stall = 1.
  - flush_cnt increments on each clock where flush_ifid = 1.
  - Both saturate at all-ones and do not wrap.
- Combinational latency: stall, bubble and flush are combinational from the inputs and slots in the same cycle. fwd_a and fwd_b have one-cycle latency.

Decomposition:
- Shared package or include file holds:
  - The FWD_RF, FWD_EXMEM and FWD_MEMWB 2-bit constants.
  - The slot field widths.
  - REG_ZERO = 5'd0.
- One sub-module, hazard_match, which is combinational: (src, uses, slot_v, slot_dst) -> hit. It is instantiated four times: rs and rt, each against the EX and MEM slots.

Test Plan:
- Load-use: lw $8 followed by add $9, $8, $10 with FORWARD_EN = 1 -> stall = 1 and bubble = 1 for exactly 1 cycle. Next cycle, fwd_a = 01 when the add is in EX. stall_cnt = 1.
- ALU chain: add $3; sub $4, $3, $3 -> no stall. fwd_a = fwd_b = 10 in the sub's EX cycle.
- Priority: add $5; or $5; and $6, $5, $0 -> fwd_a = 10, not 01. fwd_b = 00 because $0 never forwards.
- No-forward mode, FORWARD_EN = 0: add $7 followed by beq $7 -> 2 stall cycles, fwd = 00. Write to $0 followed by a reader of $0 -> no stall.
- Flush over stall: a load-use pair in ID and EX while ex_branch_taken = 1 in the same cycle -> flush_ifid = 1, bubble = 1, stall = 0. flush_cnt = 1, stall_cnt unchanged.
- Reset mid-stall: drop rst_n during a load-use stall -> stall = 0 immediately, counters = 0, fwd = 00. After release, the same reader produces no stall.
